debug_dump_sequencer: RTL and testbench
=======================================

# debug_dump_sequencer

Sequences a full debug dump of the MIPS state by stepping `o_request_select` through every register-file address and then through a list of extra debug controllers. It captures each frame the selected controller emits while its writing flag is high and buffers the frames in a FIFO. It then presents the frames on a valid/ready stream toward the host interface (UART TX framer). It sits between the debug unit (which triggers dumps after halt or step) and the per-resource debug controllers, and is their only source of request codes.

## Interface
- `NB_CONTROL_FRAME`, 32, width of one frame from any controller.
- `N_EXTRA_IDS`, 4, number of non-regfile controllers dumped after the regfile; range 0..30.
- `EXTRA_BASE_ID`, 6'b1000_00, request code of the first extra controller; extras use `EXTRA_BASE_ID + k`.
- `IDLE_CODE`, 6'b1111_11, request code that matches no controller.
- `MAX_FRAMES_PER_REQ`, 2, largest frame count any controller emits per request.
- `FIFO_DEPTH`, 8, frame FIFO depth; power of 2, ≥ `MAX_FRAMES_PER_REQ`.
- `TIMEOUT`, 8, cycles allowed from select to first `i_writing`.
- `i_clock` in 1: single clock, rising edge.
- `i_reset` in 1: synchronous, active-high.
- `i_dump_start` in 1: one-cycle start pulse; ignored while `o_busy`.
- `o_busy` out 1: high from the accepted start until `o_dump_done`.
- `o_dump_done` out 1: one-cycle pulse after the last request is captured.
- `o_error` out 1: sticky timeout flag; cleared on reset or accepted start.
- `o_request_select` out 6: code driven to all controllers.
- `i_frame` in `NB_CONTROL_FRAME`: frame from the selected controller, muxed upstream.
- `i_writing` in 1: OR of the controllers' writing flags; each high cycle carries one valid frame.
- `o_tx_data` out `NB_CONTROL_FRAME`: FIFO head.
- `o_tx_valid` out 1: FIFO not empty.
- `i_tx_ready` in 1: the consumer accepts the head when valid and ready are both high.

## Operation
- Request list: index 0..31 maps to code {1'b0, idx[4:0]}. Index 32..31+`N_EXTRA_IDS` maps to `EXTRA_BASE_ID` + (idx−32). The index counter is 6 bits.
- States: IDLE, GAP, SELECT, CAPTURE, DONE.
- IDLE:
  - `o_request_select` = `IDLE_CODE`.
  - On `i_dump_start`: clear `o_error`, set idx=0, go to GAP.
- GAP:
  - Drive `IDLE_CODE`.
  - Stay until FIFO free entries ≥ `MAX_FRAMES_PER_REQ`, minimum 1 cycle; then go to SELECT.
  - The gap is mandatory between consecutive requests. Controllers re-arm only on a rising edge of their own match, so regfile codes 0→1 without a gap would return no data.
- SELECT:
  - Drive the code for idx and count wait cycles.
  - When `i_writing`=1: push `i_frame`, go to CAPTURE.
  - When the wait count reaches `TIMEOUT` with no `i_writing`: set `o_error`, skip this index (no frame pushed) and advance as at the end of CAPTURE.
- CAPTURE:
  - Hold the code and push `i_frame` on every cycle `i_writing`=1.
  - On the first cycle `i_writing`=0: if idx is the last index, go to DONE; else idx+1 and go to GAP.
- DONE:
  - Pulse `o_dump_done`.
  - Wait until the FIFO is empty, then return to IDLE with `o_busy`=0.
- FIFO:
  - Push and pop in the same cycle are both legal at any occupancy.
  - A push when full is impossible by construction because of the GAP space check. An assertion flags it, and the frame is dropped.
- Reset mid-dump: the next cycle is IDLE, the FIFO is flushed, `o_error` is cleared, and `o_request_select` = `IDLE_CODE`.

## Timing
- Reset values: `o_request_select`=`IDLE_CODE`; `o_busy`, `o_dump_done`, `o_error`, `o_tx_valid` = 0; `o_tx_data` = 0.
- All outputs are registered, except that `o_tx_data` and `o_tx_valid` come directly from the FIFO registers.
- Start pulse at cycle t: GAP at t+1, first code driven at t+2.
- Per single-frame request with a ready consumer: 1 GAP + 1 SELECT + 1 CAPTURE-exit = 3 cycles plus controller latency. The regfile controller asserts writing 1 cycle after the code appears.
- Pushed frame is visible on `o_tx_valid` in the cycle after the push.
- `i_dump_start` during `o_busy`: ignored, no effect on the index.

## Structure
- Shared package `debug_pkg`: `IDLE_CODE`, `EXTRA_BASE_ID`, and the request-code width (6). Regfile-select bit = code[5]==0.
- One sub-module `debug_frame_fifo`: synchronous FIFO with parameters width and depth, providing push, pop, full, empty and free count.
- State encoding is local to the sequencer.

## Test plan
- Full dump with always-ready consumer and regfile model returning 32'h100+addr, `N_EXTRA_IDS`=4 single-frame models → 36 frames in order: 0x100..0x11F, then the extras; `o_dump_done` pulses once; `o_error`=0.
- Code trace check → `IDLE_CODE` appears for ≥1 cycle between every pair of consecutive codes, including codes 0→1 and 31→0x20.
- `i_tx_ready` held low → sequencer stalls in GAP with FIFO occupancy ≥ 7; no frame is lost. Releasing `i_tx_ready` resumes the dump and all 36 frames arrive.
- Extra controller 2 never asserts `i_writing` → `o_error` is set 8 cycles after its select; 35 frames arrive; the dump completes.
- Two-frame controller (`i_writing` high 2 cycles) → both frames are pushed in order, then the next index follows.
- Reset asserted while capturing idx 10 → next cycle: IDLE, `o_tx_valid`=0, code = 6'b111111. A new start then dumps from idx 0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared constants for the debug dump path.
// Request-code width, idle/extra codes and the index-to-code mapping.
package debug_pkg;

    localparam int unsigned REQ_W = 6;

    // Regfile codes have code[5] == 0; extras live above EXTRA_BASE_ID.
    localparam logic [REQ_W-1:0] IDLE_CODE     = 6'b111111;
    localparam logic [REQ_W-1:0] EXTRA_BASE_ID = 6'b100000;

    // Index 0..31 selects a regfile address, index 32+k selects extra k.
    function automatic logic [REQ_W-1:0] req_code(
        input logic [REQ_W-1:0] idx,
        input logic [REQ_W-1:0] extra_base
    );
        if (!idx[REQ_W-1]) begin
            return {1'b0, idx[REQ_W-2:0]};
        end
        return extra_base + {1'b0, idx[REQ_W-2:0]};
    endfunction

endpackage

// File: rtl/debug_frame_fifo.sv
// Synchronous frame FIFO with free-entry count.
// Ports: clk_i, rst_i (sync, high), push_i/data_i, pop_i/data_o, full_o, empty_o, free_o.
module debug_frame_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    free_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             do_pop;
    logic             do_push;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign free_o  = CW'(DEPTH) - cnt_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A simultaneous pop frees the slot, so push+pop is fine when full.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
        end
    end

    // Upstream space check should make an overflowing push unreachable.
    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(push_i && full_o && !do_pop)
    );

endmodule

// File: rtl/debug_dump_sequencer.sv
// Walks every regfile address and extra controller, captures frames, streams them out.
// Ports: i_clock, i_reset, dump start/busy/done/error, request select, frame capture, tx stream.
module debug_dump_sequencer
    import debug_pkg::*;
#(
    parameter int unsigned      NB_CONTROL_FRAME   = 32,
    parameter int unsigned      N_EXTRA_IDS        = 4,
    parameter logic [REQ_W-1:0] EXTRA_BASE_ID      = debug_pkg::EXTRA_BASE_ID,
    parameter logic [REQ_W-1:0] IDLE_CODE          = debug_pkg::IDLE_CODE,
    parameter int unsigned      MAX_FRAMES_PER_REQ = 2,
    parameter int unsigned      FIFO_DEPTH         = 8,
    parameter int unsigned      TIMEOUT            = 8
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_dump_start,
    output logic                        o_busy,
    output logic                        o_dump_done,
    output logic                        o_error,
    output logic [REQ_W-1:0]            o_request_select,
    input  logic [NB_CONTROL_FRAME-1:0] i_frame,
    input  logic                        i_writing,
    output logic [NB_CONTROL_FRAME-1:0] o_tx_data,
    output logic                        o_tx_valid,
    input  logic                        i_tx_ready
);

    localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    localparam logic [REQ_W-1:0] LAST_IDX  = REQ_W'(31 + N_EXTRA_IDS);
    localparam logic [FCW-1:0]   NEED_FREE = FCW'(MAX_FRAMES_PER_REQ);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_SELECT,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e           state_q;
    logic [REQ_W-1:0] idx_q;
    logic [TW-1:0]    wait_q;
    logic [REQ_W-1:0] sel_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             push;
    logic             pop;
    logic             adv;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FCW-1:0]   fifo_free;

    assign push = i_writing &&
                  (state_q == S_SELECT || state_q == S_CAPTURE);
    assign pop  = o_tx_valid && i_tx_ready;

    // End of a request: writing dropped in CAPTURE, or SELECT timed out.
    assign adv = !i_writing &&
                 ((state_q == S_CAPTURE) ||
                  (state_q == S_SELECT && wait_q == TW'(TIMEOUT - 1)));

    debug_frame_fifo #(
        .WIDTH (NB_CONTROL_FRAME),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (i_clock),
        .rst_i   (i_reset),
        .push_i  (push),
        .data_i  (i_frame),
        .pop_i   (pop),
        .data_o  (o_tx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .free_o  (fifo_free)
    );

    assign o_tx_valid       = !fifo_empty;
    assign o_busy           = busy_q;
    assign o_dump_done      = done_q;
    assign o_error          = err_q;
    assign o_request_select = sel_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wait_q  <= '0;
            sel_q   <= IDLE_CODE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (i_dump_start) begin
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_GAP;
                    end
                end
                // Idle code between requests lets controllers re-arm.
                S_GAP: begin
                    if (!fifo_full && fifo_free >= NEED_FREE) begin
                        sel_q   <= req_code(idx_q, EXTRA_BASE_ID);
                        wait_q  <= '0;
                        state_q <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (i_writing) begin
                        state_q <= S_CAPTURE;
                    end else if (wait_q == TW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
                end
                S_CAPTURE: begin
                end
                S_DONE: begin
                    if (fifo_empty) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            if (adv) begin
                sel_q <= IDLE_CODE;
                if (idx_q == LAST_IDX) begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    idx_q   <= idx_q + REQ_W'(1);
                    state_q <= S_GAP;
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer with a behavioural controller model.
// Checks reset state, full dump order, gaps, back-pressure, timeout, multi-frame and mid-dump reset.
module tb_debug_dump_sequencer;

    localparam logic [5:0] IDLE = 6'h3F;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_dump_start;
    logic        o_busy;
    logic        o_dump_done;
    logic        o_error;
    logic [5:0]  o_request_select;
    logic [31:0] i_frame;
    logic        i_writing;
    logic [31:0] o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;

    always #5 i_clock = ~i_clock;

    debug_dump_sequencer dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_dump_start     (i_dump_start),
        .o_busy           (o_busy),
        .o_dump_done      (o_dump_done),
        .o_error          (o_error),
        .o_request_select (o_request_select),
        .i_frame          (i_frame),
        .i_writing        (i_writing),
        .o_tx_data        (o_tx_data),
        .o_tx_valid       (o_tx_valid),
        .i_tx_ready       (i_tx_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int miss_k   = -1;
    int two_idx  = -1;
    int cyc      = 0;
    int wr_cnt   = 0;

    always @(posedge i_clock) begin
        cyc++;
        if (i_writing) wr_cnt++;
    end

    // Controller model: re-arms on a new non-idle code, writes 1 cycle later.
    int          emit_left = 0;
    int          emit_n    = 0;
    int          k;
    logic [31:0] base      = '0;
    logic [5:0]  prev_sel  = IDLE;

    always @(negedge i_clock) begin
        i_writing = 1'b0;
        if (emit_left > 0) begin
            i_writing = 1'b1;
            i_frame   = (emit_n == 0) ? base : (base | 32'h8000_0000);
            emit_n++;
            emit_left--;
        end
        if (o_request_select != prev_sel && o_request_select != IDLE) begin
            emit_n = 0;
            if (!o_request_select[5]) begin
                base      = 32'h100 + 32'(o_request_select[4:0]);
                emit_left = (int'(o_request_select[4:0]) == two_idx) ? 2 : 1;
            end else begin
                k         = int'(o_request_select) - 32;
                base      = 32'h200 + 32'(k);
                emit_left = (k == miss_k) ? 0 : 1;
            end
        end
        prev_sel = o_request_select;
    end

    // Stream consumer, done counter and code-trace monitor.
    logic [31:0] got[$];
    logic [31:0] exp_q[$];
    int          done_cnt  = 0;
    int          trace_bad = 0;
    logic [5:0]  last_code = IDLE;

    always @(negedge i_clock) begin
        if (!i_reset && o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
        if (o_dump_done) done_cnt++;
        if (o_request_select != last_code && o_request_select != IDLE &&
            last_code != IDLE) trace_bad++;
        last_code = o_request_select;
    end

    task automatic build_exp();
        exp_q.delete();
        for (int a = 0; a < 32; a++) begin
            exp_q.push_back(32'h100 + 32'(a));
            if (a == two_idx) exp_q.push_back((32'h100 + 32'(a)) | 32'h8000_0000);
        end
        for (int e = 0; e < 4; e++) begin
            if (e != miss_k) exp_q.push_back(32'h200 + 32'(e));
        end
    endtask

    task automatic start_pulse();
        @(posedge i_clock); #1 i_dump_start = 1'b1;
        @(posedge i_clock); #1 i_dump_start = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clock);
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_dump_start = 1'b0; i_tx_ready = 1'b1;
        i_frame = '0;   i_writing = 1'b0;
        repeat (3) @(posedge i_clock);
        #1 i_reset = 1'b0;
        @(negedge i_clock);
        n_checks++; if (o_request_select !== IDLE) $display("FAIL rst_sel: got %h want %h", o_request_select, IDLE); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", o_busy); else n_pass++;
        n_checks++; if (o_dump_done !== 1'b0) $display("FAIL rst_done: got %b want 0", o_dump_done); else n_pass++;
        n_checks++; if (o_error !== 1'b0) $display("FAIL rst_error: got %b want 0", o_error); else n_pass++;
        n_checks++; if (o_tx_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", o_tx_valid); else n_pass++;
        n_checks++; if (o_tx_data !== 32'h0) $display("FAIL rst_data: got %h want 0", o_tx_data); else n_pass++;
    endtask

    task automatic test_full_dump();
        bit ok;
        miss_k = -1; two_idx = -1; build_exp();
        got.delete(); done_cnt = 0; trace_bad = 0;
        start_pulse();
        @(negedge i_clock);
        n_checks++; if (o_busy !== 1'b1) $display("FAIL full_busy: got %b want 1", o_busy); else n_pass++;
        n_checks++; if (o_request_select !== IDLE) $display("FAIL full_gap: got %h want %h", o_request_select, IDLE); else n_pass++;
        @(negedge i_clock);
        n_checks++; if (o_request_select !== 6'h00) $display("FAIL full_first_code: got %h want 00", o_request_select); else n_pass++;
        repeat (20) @(posedge i_clock);
        #1 i_dump_start = 1'b1;
        @(posedge i_clock); #1 i_dump_start = 1'b0;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL full_timeout: busy got 1 want 0"); else n_pass++;
        n_checks++; if (got.size() !== exp_q.size()) $display("FAIL full_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i])
                $display("FAIL full_frame[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL full_done_cnt: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (o_error !== 1'b0) $display("FAIL full_error: got %b want 0", o_error); else n_pass++;
        n_checks++; if (trace_bad !== 0) $display("FAIL full_gap_trace: got %0d want 0", trace_bad); else n_pass++;
        repeat (5) @(negedge i_clock);
        n_checks++; if (o_busy !== 1'b0) $display("FAIL full_idle_after: got %b want 0", o_busy); else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        miss_k = -1; two_idx = -1; build_exp();
        @(posedge i_clock); #1 i_tx_ready = 1'b0;
        got.delete(); done_cnt = 0; trace_bad = 0; wr_cnt = 0;
        start_pulse();
        repeat (80) @(negedge i_clock);
        n_checks++; if (wr_cnt !== 7) $display("FAIL stall_pushed: got %0d want 7", wr_cnt); else n_pass++;
        n_checks++; if (o_request_select !== IDLE) $display("FAIL stall_gap: got %h want %h", o_request_select, IDLE); else n_pass++;
        n_checks++; if (o_busy !== 1'b1) $display("FAIL stall_busy: got %b want 1", o_busy); else n_pass++;
        n_checks++; if (o_tx_data !== 32'h100) $display("FAIL stall_head: got %h want 00000100", o_tx_data); else n_pass++;
        @(posedge i_clock); #1 i_tx_ready = 1'b1;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL stall_timeout: busy got 1 want 0"); else n_pass++;
        n_checks++; if (got.size() !== exp_q.size()) $display("FAIL stall_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i])
                $display("FAIL stall_frame[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (trace_bad !== 0) $display("FAIL stall_gap_trace: got %0d want 0", trace_bad); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int t_sel = -1;
        int t_err = -1;
        miss_k = 2; two_idx = -1; build_exp();
        got.delete(); done_cnt = 0; trace_bad = 0;
        start_pulse();
        for (int i = 0; i < 600; i++) begin
            @(negedge i_clock);
            if (o_request_select == 6'h22 && t_sel < 0) begin
                t_sel = cyc;
                n_checks++; if (o_error !== 1'b0) $display("FAIL to_err_early: got %b want 0", o_error); else n_pass++;
            end
            if (o_error && t_err < 0) t_err = cyc;
            if (t_sel >= 0 && t_err >= 0) break;
        end
        n_checks++; if (t_sel < 0 || t_err - t_sel !== 8) $display("FAIL to_latency: got %0d want 8", t_err - t_sel); else n_pass++;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL to_timeout: busy got 1 want 0"); else n_pass++;
        n_checks++; if (got.size() !== 35) $display("FAIL to_count: got %0d want 35", got.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i])
                $display("FAIL to_frame[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (o_error !== 1'b1) $display("FAIL to_sticky: got %b want 1", o_error); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL to_done_cnt: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (trace_bad !== 0) $display("FAIL to_gap_trace: got %0d want 0", trace_bad); else n_pass++;
    endtask

    task automatic test_two_frame();
        bit ok;
        miss_k = -1; two_idx = 5; build_exp();
        got.delete(); done_cnt = 0; trace_bad = 0;
        start_pulse();
        @(negedge i_clock);
        n_checks++; if (o_error !== 1'b0) $display("FAIL two_err_clear: got %b want 0", o_error); else n_pass++;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL two_timeout: busy got 1 want 0"); else n_pass++;
        n_checks++; if (got.size() !== 37) $display("FAIL two_count: got %0d want 37", got.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i])
                $display("FAIL two_frame[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
            else n_pass++;
        end
        n_checks++; if (done_cnt !== 1) $display("FAIL two_done_cnt: got %0d want 1", done_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        miss_k = -1; two_idx = -1; build_exp();
        got.delete(); done_cnt = 0;
        start_pulse();
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clock);
            if (o_request_select == 6'h0A) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++; if (!seen) $display("FAIL mid_reach_idx10: got 0 want 1"); else n_pass++;
        @(posedge i_clock);
        @(posedge i_clock); #1 i_reset = 1'b1;
        @(posedge i_clock); #1 i_reset = 1'b0;
        @(negedge i_clock);
        n_checks++; if (o_request_select !== IDLE) $display("FAIL mid_sel: got %h want %h", o_request_select, IDLE); else n_pass++;
        n_checks++; if (o_tx_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", o_tx_valid); else n_pass++;
        n_checks++; if (o_busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", o_busy); else n_pass++;
        repeat (4) @(negedge i_clock);
        got.delete(); done_cnt = 0; trace_bad = 0;
        start_pulse();
        @(negedge i_clock);
        @(negedge i_clock);
        n_checks++; if (o_request_select !== 6'h00) $display("FAIL mid_restart_code: got %h want 00", o_request_select); else n_pass++;
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL mid_timeout: busy got 1 want 0"); else n_pass++;
        n_checks++; if (got.size() !== 36) $display("FAIL mid_count: got %0d want 36", got.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= got.size() || got[i] !== exp_q[i])
                $display("FAIL mid_frame[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 32'hx, exp_q[i]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_stall();
        test_timeout();
        test_two_frame();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
